// File: rtl/present_core_param.sv
// PRESENT block cipher core, one round per clock, 80- or 128-bit key, valid/ready on both sides.
// Define PRESENT_DEC_EN to build the decrypt path; without it every block is encrypted.
module present_core_param #(
  parameter int KEY_W  = 128,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [KEY_W-1:0] in_key,
  input  logic             in_decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy
);

  localparam int         CTR_LO = (KEY_W == 80) ? 15 : 62;
  localparam int         S2_HI  = KEY_W - 5;
  localparam int         S2_LO  = KEY_W - 8;
  localparam logic [4:0] LAST   = 5'(ROUNDS);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_core_param: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_core_param: ROUNDS must be in 1..31");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, KEYEXP = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  4'hF: return 4'h2;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
    return y;
  endfunction

  // Bit i moves to i*16 mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    t[KEY_W-1:KEY_W-4] = sbox(t[KEY_W-1:KEY_W-4]);
    if (KEY_W == 128) t[S2_HI:S2_LO] = sbox(t[S2_HI:S2_LO]);
    t[CTR_LO+4:CTR_LO] = t[CTR_LO+4:CTR_LO] ^ c;
    return t;
  endfunction

  state_t           r_fsm, w_fsm_nxt;
  logic [63:0]      r_blk, r_out;
  logic [KEY_W-1:0] r_key, w_key_nxt;
  logic [4:0]       r_cnt;
  logic             r_in_ready, r_out_valid, r_busy;
  logic [63:0]      w_rk, w_enc_blk, w_enc_last;
  logic             w_accept, w_dec_req, w_run_last;

  assign w_accept   = in_valid && r_in_ready;
  assign w_rk       = r_key[KEY_W-1:KEY_W-64];
  assign w_key_nxt  = key_fwd(r_key, r_cnt);
  assign w_enc_blk  = p_layer(sbox_layer(r_blk ^ w_rk));
  assign w_enc_last = w_enc_blk ^ w_key_nxt[KEY_W-1:KEY_W-64];

`ifdef PRESENT_DEC_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  4'hF: return 4'hA;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [63:0] sbox_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox_inv(x[4*i +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_inv(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 63; i++) y[i] = x[(i * 16) % 63];
    y[63] = x[63];
    return y;
  endfunction

  // Undo one schedule step: counter XOR, S-box, then rotate right 61.
  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] t;
    t = k;
    t[CTR_LO+4:CTR_LO] = t[CTR_LO+4:CTR_LO] ^ c;
    t[KEY_W-1:KEY_W-4] = sbox_inv(t[KEY_W-1:KEY_W-4]);
    if (KEY_W == 128) t[S2_HI:S2_LO] = sbox_inv(t[S2_HI:S2_LO]);
    return {t[60:0], t[KEY_W-1:61]};
  endfunction

  logic             r_dec, r_first;
  logic [KEY_W-1:0] w_key_prev;
  logic [63:0]      w_dec_blk;

  assign w_dec_req  = in_decrypt;
  assign w_key_prev = key_inv(r_key, r_cnt);
  assign w_dec_blk  = sbox_inv_layer(p_inv(r_blk)) ^ w_key_prev[KEY_W-1:KEY_W-64];
  assign w_run_last = r_dec ? (!r_first && r_cnt == 5'd1) : (r_cnt == LAST);
`else
  logic w_unused_decrypt;
  assign w_unused_decrypt = in_decrypt;
  assign w_dec_req        = 1'b0;
  assign w_run_last       = (r_cnt == LAST);
`endif

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    w_fsm_nxt = w_accept ? (w_dec_req ? KEYEXP : RUN) : IDLE;
      KEYEXP:  w_fsm_nxt = (r_cnt == LAST) ? RUN : KEYEXP;
      RUN:     w_fsm_nxt = w_run_last ? DONE : RUN;
      DONE:    w_fsm_nxt = out_ready ? IDLE : DONE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_in_ready  <= (w_fsm_nxt == IDLE);
      r_out_valid <= (w_fsm_nxt == DONE);
      r_busy      <= (w_fsm_nxt != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk <= 64'h0;
      r_key <= {KEY_W{1'b0}};
      r_cnt <= 5'd0;
      r_out <= 64'h0;
`ifdef PRESENT_DEC_EN
      r_dec   <= 1'b0;
      r_first <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_blk <= in_data;
            r_key <= in_key;
            r_cnt <= 5'd1;
`ifdef PRESENT_DEC_EN
            r_dec   <= w_dec_req;
            r_first <= 1'b1;
`endif
          end
        end
        KEYEXP: begin
          r_key <= w_key_nxt;
          r_cnt <= (r_cnt == LAST) ? LAST : r_cnt + 5'd1;
        end
        RUN: begin
`ifdef PRESENT_DEC_EN
          if (r_dec) begin
            if (r_first) begin
              r_blk   <= r_blk ^ w_rk;
              r_first <= 1'b0;
            end else begin
              r_blk <= w_dec_blk;
              r_key <= w_key_prev;
              if (r_cnt == 5'd1) r_out <= w_dec_blk;
              else r_cnt <= r_cnt - 5'd1;
            end
          end else
`endif
          begin
            r_blk <= w_enc_blk;
            r_key <= w_key_nxt;
            if (r_cnt == LAST) r_out <= w_enc_last;
            else r_cnt <= r_cnt + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) r_cnt <= 5'd0;
        end
        default: r_cnt <= 5'd0;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;
  assign busy      = r_busy;

endmodule

// File: tb/tb_present_core_param.sv
// Randomised bench for present_core_param: 80- and 128-bit cores in lockstep against a
// round-key-table reference model, plus known-answer, backpressure and reset cases.
module tb_present_core_param;

  localparam int R = 31;
`ifdef PRESENT_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_decrypt, out_ready;
  logic [63:0]  in_data;
  logic [127:0] key128;
  logic [79:0]  key80;
  logic         rdy80, ov80, busy80, rdy128, ov128, busy128;
  logic [63:0]  od80, od128;

  always #5 clk = ~clk;

  present_core_param #(.KEY_W(80), .ROUNDS(R)) dut80 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy80), .in_data(in_data),
    .in_key(key80), .in_decrypt(in_decrypt), .out_valid(ov80), .out_ready(out_ready),
    .out_data(od80), .busy(busy80));

  present_core_param #(.KEY_W(128), .ROUNDS(R)) dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy128), .in_data(in_data),
    .in_key(key128), .in_decrypt(in_decrypt), .out_valid(ov128), .out_ready(out_ready),
    .out_data(od128), .busy(busy128));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] tab;
    tab = 64'h2174_8FE3_DA09_B65C;
    return tab[4*x +: 4];
  endfunction

  function automatic logic [3:0] sb_inv(input logic [3:0] y);
    logic [3:0] r;
    r = 4'h0;
    for (int v = 0; v < 16; v++) if (sb(4'(v)) == y) r = 4'(v);
    return r;
  endfunction

  function automatic int pos(input int i);
    return (i == 63) ? 63 : (i * 16) % 63;
  endfunction

  function automatic logic [63:0] perm(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) begin
      if (inv) y[i] = x[pos(i)];
      else     y[pos(i)] = x[i];
    end
    return y;
  endfunction

  function automatic logic [63:0] subst(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = inv ? sb_inv(x[4*i +: 4]) : sb(x[4*i +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] present_ref(input logic [63:0] d, input logic [127:0] key,
                                              input int kw, input bit dec);
    logic [63:0]  rk [1:32];
    logic [127:0] k;
    logic [63:0]  s;
    k = key;
    for (int i = 1; i <= R + 1; i++) begin
      if (kw == 80) begin
        rk[i]     = k[79:16];
        k[79:0]   = {k[18:0], k[79:19]};
        k[79:76]  = sb(k[79:76]);
        k[19:15] ^= 5'(i);
      end else begin
        rk[i]      = k[127:64];
        k          = {k[66:0], k[127:67]};
        k[127:124] = sb(k[127:124]);
        k[123:120] = sb(k[123:120]);
        k[66:62]  ^= 5'(i);
      end
    end
    if (!dec) begin
      s = d;
      for (int i = 1; i <= R; i++) s = perm(subst(s ^ rk[i], 1'b0), 1'b0);
      s ^= rk[R+1];
    end else begin
      s = d ^ rk[R+1];
      for (int i = R; i >= 1; i--) s = subst(perm(s, 1'b1), 1'b1) ^ rk[i];
    end
    return s;
  endfunction

  // Transaction-level timing model: idle / busy for a fixed latency / holding a result.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mst_t;
  mst_t        m_st = M_IDLE;
  int          m_left;
  bit          m_d;
  logic [63:0] m_exp80, m_exp128, m_out80, m_out128;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_st = M_IDLE;
      m_out80 = 64'h0;
      m_out128 = 64'h0;
    end else begin
      case (m_st)
        M_IDLE: if (in_valid) begin
          m_d      = in_decrypt && DEC_EN;
          m_exp80  = present_ref(in_data, {48'h0, key80}, 80, m_d);
          m_exp128 = present_ref(in_data, key128, 128, m_d);
          m_left   = m_d ? 2 * R + 1 : R;
          m_st     = M_BUSY;
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) begin
            m_st = M_DONE;
            m_out80 = m_exp80;
            m_out128 = m_exp128;
          end
        end
        M_DONE: if (out_ready) m_st = M_IDLE;
        default: m_st = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("in_ready80",  64'(rdy80),   64'(m_st == M_IDLE));
      chk("busy80",      64'(busy80),  64'(m_st != M_IDLE));
      chk("out_valid80", 64'(ov80),    64'(m_st == M_DONE));
      chk("in_ready128", 64'(rdy128),  64'(m_st == M_IDLE));
      chk("busy128",     64'(busy128), 64'(m_st != M_IDLE));
      chk("out_valid128", 64'(ov128),  64'(m_st == M_DONE));
      if (m_st == M_DONE) begin
        chk("out_data80",  od80,  m_out80);
        chk("out_data128", od128, m_out128);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_block(input logic [63:0] d, input logic [127:0] k, input bit dec,
                           input int hold, output logic [63:0] r80, output logic [63:0] r128,
                           output int lat);
    int n;
    in_valid = 1'b1; in_data = d; key128 = k; key80 = k[79:0]; in_decrypt = dec;
    out_ready = 1'b0;
    n = 0;
    while (!rdy80 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    key128 = {$urandom, $urandom, $urandom, $urandom};
    key80 = key128[79:0];
    in_decrypt = 1'($urandom_range(0, 1));
    lat = 0;
    while (!ov80 && lat < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("out_valid_timeout", 64'd0, 64'd1);
    r80 = od80;
    r128 = od128;
    in_valid = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 64'(rdy80 & rdy128), 64'd1);
    chk({tag, "_busy"}, 64'(busy80 | busy128), 64'd0);
    chk({tag, "_out_valid"}, 64'(ov80 | ov128), 64'd0);
    chk({tag, "_out_data80"}, od80, 64'h0);
    chk({tag, "_out_data128"}, od128, 64'h0);
  endtask

  initial begin
    logic [63:0] r80, r128;
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_data = 64'h0; key128 = 128'h0; key80 = 80'h0;
    in_decrypt = 1'b0; out_ready = 1'b0;

    chk("ref_kat80_zero", present_ref(64'h0, 128'h0, 80, 1'b0), 64'h5579C1387B228445);
    chk("ref_kat80_ones", present_ref(64'hFFFF_FFFF_FFFF_FFFF, {48'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF},
                                      80, 1'b0), 64'h3333DCD3213210D2);
    chk("ref_kat128_zero", present_ref(64'h0, 128'h0, 128, 1'b0), 64'h96DB702A2E6900AF);
    chk("ref_dec128", present_ref(64'h96DB702A2E6900AF, 128'h0, 128, 1'b1), 64'h0);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst = 1'b0;

    run_block(64'h0, 128'h0, 1'b0, 0, r80, r128, lat);
    chk("kat80_zero", r80, 64'h5579C1387B228445);
    chk("kat128_zero", r128, 64'h96DB702A2E6900AF);
    chk("enc_latency", 64'(lat), 64'd31);

    run_block(64'hFFFF_FFFF_FFFF_FFFF, {128{1'b1}}, 1'b0, 1, r80, r128, lat);
    chk("kat80_ones", r80, 64'h3333DCD3213210D2);

    run_block(64'h96DB702A2E6900AF, 128'h0, 1'b1, 2, r80, r128, lat);
    chk("dec128_zero", r128,
        DEC_EN ? 64'h0 : present_ref(64'h96DB702A2E6900AF, 128'h0, 128, 1'b0));
    chk("dec_latency", 64'(lat), DEC_EN ? 64'd63 : 64'd31);

    run_block(64'h0, 128'h0, 1'b1, 10, r80, r128, lat);
    chk("dec80_bp", r80, DEC_EN ? present_ref(64'h0, 128'h0, 80, 1'b1) : 64'h5579C1387B228445);

    // Abandon an encrypt mid-flight; reset also beats a simultaneous in_valid.
    in_valid = 1'b1; in_data = {$urandom, $urandom}; key128 = {$urandom, $urandom, $urandom, $urandom};
    key80 = key128[79:0]; in_decrypt = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("mid_rst");
    @(posedge clk); #1;
    chk_reset_state("rst_vs_valid");
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    run_block(64'h0, 128'h0, 1'b0, 0, r80, r128, lat);
    chk("after_rst_kat80", r80, 64'h5579C1387B228445);
    chk("after_rst_kat128", r128, 64'h96DB702A2E6900AF);

    for (int b = 0; b < 30; b++) begin
      run_block({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 1)), $urandom_range(0, 3), r80, r128, lat);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
